// File: rtl/ro_pkg.sv
// Purpose : types and helpers shared by the ring-oscillator FIFO drain logic.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package ro_pkg;

   // Drain controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } drain_state_t;

   // Number of whole FIFO samples that fit in one output word.
   function automatic int spw(input int out_w, input int fifo_w);
      return out_w / fifo_w;
   endfunction

endpackage

// File: rtl/ro_fifo_drain.sv
// Purpose : pops num_samples results from a show-ahead FIFO after a start pulse and
//           packs them little-endian (lane 0 in the LSBs) into OUT_WIDTH-bit words.
// Latency : a full word is presented SPW cycles after its first pop when the FIFO
//           stays non-empty; one bubble cycle follows each accepted word.
// Backpressure: out_valid/out_ready; the word is held stable and FIFO pops stop
//           while out_valid && !out_ready. An empty FIFO stalls packing.
// Ports   : clk, afu_rst_n (sync, active-low), start/num_samples (run control),
//           fifo_empty/fifo_rd_data/fifo_rd_en (FIFO read side),
//           out_valid/out_ready/out_data/out_count/out_last (word stream),
//           busy (run in progress), done (one-cycle end-of-run pulse).
module ro_fifo_drain
   import ro_pkg::*;
#(
   parameter  int FIFO_WIDTH       = 20,
   parameter  int OUT_WIDTH        = 64,
   parameter  int NUM_SAMPLE_WIDTH = 16,
   localparam int SPW              = spw(OUT_WIDTH, FIFO_WIDTH),
   localparam int CNT_WIDTH        = $clog2(SPW + 1)
) (
   input  logic                        clk,
   input  logic                        afu_rst_n,
   input  logic                        start,
   input  logic [NUM_SAMPLE_WIDTH-1:0] num_samples,
   input  logic                        fifo_empty,
   input  logic [FIFO_WIDTH-1:0]       fifo_rd_data,
   output logic                        fifo_rd_en,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [OUT_WIDTH-1:0]        out_data,
   output logic [CNT_WIDTH-1:0]        out_count,
   output logic                        out_last,
   output logic                        busy,
   output logic                        done
);

   localparam logic [NUM_SAMPLE_WIDTH-1:0] CNT_ONE  = NUM_SAMPLE_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]        LANE_ONE = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]        LANE_MAX = CNT_WIDTH'(SPW);
   localparam logic [CNT_WIDTH-1:0]        LANE_TOP = CNT_WIDTH'(SPW - 1);

   drain_state_t                 state_q, state_d;
   logic [NUM_SAMPLE_WIDTH-1:0]  target_q;
   logic [NUM_SAMPLE_WIDTH-1:0]  rd_cnt_q;
   logic [CNT_WIDTH-1:0]         lane_idx_q;
   logic [FIFO_WIDTH-1:0]        lane_q [SPW];

   logic                         word_full;
   logic                         last_pop;
   logic                         word_fire;
   logic [OUT_WIDTH-1:0]         pack_d;

   assign word_full = (lane_idx_q == LANE_TOP);
   assign last_pop  = ((rd_cnt_q + CNT_ONE) == target_q);
   assign word_fire = out_valid && out_ready;

   // Word as it will look after the current pop lands in lane[lane_idx_q].
   // Lanes not yet written are already 0, so pad and unused lanes stay 0.
   always_comb begin
      pack_d = '0;
      for (int i = 0; i < SPW; i++) begin
         if (CNT_WIDTH'(i) == lane_idx_q)
            pack_d[i*FIFO_WIDTH +: FIFO_WIDTH] = fifo_rd_data;
         else
            pack_d[i*FIFO_WIDTH +: FIFO_WIDTH] = lane_q[i];
      end
   end

   // Next-state and decoded outputs.
   always_comb begin
      state_d    = state_q;
      fifo_rd_en = 1'b0;
      busy       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start)
               state_d = (num_samples == '0) ? DONE : FILL;
         end
         FILL: begin
            busy = 1'b1;
            // Gated by reset so a synchronous reset never coincides with a pop.
            fifo_rd_en = afu_rst_n && !fifo_empty &&
                         (lane_idx_q < LANE_MAX) && (rd_cnt_q < target_q);
            if (fifo_rd_en && (word_full || last_pop))
               state_d = EMIT;
         end
         EMIT: begin
            busy = 1'b1;
            if (word_fire)
               state_d = out_last ? DONE : FILL;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!afu_rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Datapath: counters, lane registers and the registered word interface.
   always_ff @(posedge clk) begin
      if (!afu_rst_n) begin
         target_q   <= '0;
         rd_cnt_q   <= '0;
         lane_idx_q <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_count  <= '0;
         out_last   <= 1'b0;
         done       <= 1'b0;
         for (int i = 0; i < SPW; i++)
            lane_q[i] <= '0;
      end else begin
         // done lags the DONE state by one cycle and lasts exactly one cycle.
         done <= (state_q == DONE);

         if (state_q == IDLE && start) begin
            target_q   <= num_samples;
            rd_cnt_q   <= '0;
            lane_idx_q <= '0;
         end

         if (fifo_rd_en) begin
            for (int i = 0; i < SPW; i++) begin
               if (CNT_WIDTH'(i) == lane_idx_q)
                  lane_q[i] <= fifo_rd_data;
            end
            lane_idx_q <= lane_idx_q + LANE_ONE;
            rd_cnt_q   <= rd_cnt_q + CNT_ONE;
            if (word_full || last_pop) begin
               out_valid <= 1'b1;
               out_data  <= pack_d;
               out_count <= lane_idx_q + LANE_ONE;
               out_last  <= last_pop;
            end
         end

         // Accepted word: drop valid and clear lanes for the next word.
         if (state_q == EMIT && word_fire) begin
            out_valid  <= 1'b0;
            lane_idx_q <= '0;
            for (int i = 0; i < SPW; i++)
               lane_q[i] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ro_fifo_drain.sv
module tb_ro_fifo_drain;

   localparam int FW  = 20;
   localparam int OW  = 64;
   localparam int NSW = 16;
   localparam int SPW = 3;
   localparam int CW  = 2;

   logic           clk = 1'b0;
   logic           afu_rst_n = 1'b0;
   logic           start = 1'b0;
   logic [NSW-1:0] num_samples = '0;
   logic           fifo_empty = 1'b1;
   logic [FW-1:0]  fifo_rd_data = '0;
   logic           fifo_rd_en;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [OW-1:0]  out_data;
   logic [CW-1:0]  out_count;
   logic           out_last;
   logic           busy;
   logic           done;

   always #5 clk = ~clk;

   ro_fifo_drain #(.FIFO_WIDTH(FW), .OUT_WIDTH(OW), .NUM_SAMPLE_WIDTH(NSW)) dut (
      .clk(clk), .afu_rst_n(afu_rst_n), .start(start), .num_samples(num_samples),
      .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_last(out_last), .busy(busy), .done(done)
   );

   int checks = 0;
   int failures = 0;

   // FIFO contents and expected word stream.
   logic [FW-1:0] fq[$];
   logic [OW-1:0] exp_data[$];
   int            exp_cnt[$];
   bit            exp_last[$];

   int  pops = 0, words = 0, done_cnt = 0, exp_words = 0, exp_pops = 0;
   bit  pop_pending = 0, gap_en = 0, gap_phase = 0;
   int  ready_mode = 0;  // 0: low, 1: high, 2: random
   logic [OW-1:0] last_word = '0;

   bit            prev_stall = 0;
   logic [OW-1:0] prev_data;
   logic [CW-1:0] prev_count;
   logic          prev_last;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO model: pop the head after an edge on which rd_en was high, then
   // present the new head / empty flag.
   always @(posedge clk) begin
      #1;
      if (pop_pending && fq.size() > 0) begin
         void'(fq.pop_front());
         pops++;
      end
      gap_phase = ~gap_phase;
      fifo_empty = (fq.size() == 0) || (gap_en && gap_phase);
      fifo_rd_data = (fq.size() > 0) ? fq[0] : '0;
      case (ready_mode)
         0: out_ready = 1'b0;
         1: out_ready = 1'b1;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Compare process: outputs are stable at the falling edge.
   always @(negedge clk) begin
      pop_pending = fifo_rd_en;
      if (afu_rst_n) begin
         if (fifo_rd_en) chk("rd_en_while_empty", 64'(fifo_empty), 64'd0);
         if (prev_stall) begin
            chk("hold_data", out_data, prev_data);
            chk("hold_count", 64'(out_count), 64'(prev_count));
            chk("hold_last", 64'(out_last), 64'(prev_last));
            chk("rd_en_in_stall", 64'(fifo_rd_en), 64'd0);
         end
         if (out_valid && out_ready) begin
            if (exp_data.size() == 0) begin
               chk("unexpected_word", 64'(out_data), 64'd0 - 64'd1);
            end else begin
               chk("word_data", out_data, exp_data.pop_front());
               chk("word_count", 64'(out_count), 64'(exp_cnt.pop_front()));
               chk("word_last", 64'(out_last), 64'(exp_last.pop_front()));
            end
            words++;
            last_word = out_data;
         end
         if (done) done_cnt++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_count = out_count;
         prev_last  = out_last;
      end else begin
         prev_stall = 0;
      end
   end

   // Load samples into the FIFO model (only while the drain is idle).
   task automatic load(input int n, input int base, input bit rnd);
      for (int i = 0; i < n; i++)
         fq.push_back(rnd ? FW'($urandom) : FW'(base + i));
      @(posedge clk); #1;
   endtask

   // Model of the expected output: the first n queued samples in groups of SPW.
   task automatic start_run(input int n);
      logic [OW-1:0] w;
      exp_data.delete(); exp_cnt.delete(); exp_last.delete();
      exp_words = 0;
      for (int b = 0; b < n; b += SPW) begin
         int c = (n - b < SPW) ? (n - b) : SPW;
         w = '0;
         for (int j = 0; j < c; j++) w[j*FW +: FW] = fq[b+j];
         exp_data.push_back(w);
         exp_cnt.push_back(c);
         exp_last.push_back(b + c == n);
         exp_words++;
      end
      exp_pops = n;
      pops = 0; words = 0; done_cnt = 0;
      num_samples = NSW'(n);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      num_samples = NSW'($urandom);
   endtask

   task automatic wait_done(input string name, input int budget);
      int k = 0;
      while (done_cnt == 0 && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      chk({name, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      chk({name, "_done_once"}, 64'(done_cnt), 64'd1);
      chk({name, "_pops"}, 64'(pops), 64'(exp_pops));
      chk({name, "_words"}, 64'(words), 64'(exp_words));
      chk({name, "_busy_end"}, 64'(busy), 64'd0);
   endtask

   initial begin
      int k;
      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_count", 64'(out_count), 64'd0);
      chk("rst_busy_done", 64'({busy, done, fifo_rd_en}), 64'd0);
      @(posedge clk); #1;
      afu_rst_n = 1'b1;
      ready_mode = 1;
      @(posedge clk); #1;

      // Full word 1,2,3.
      load(3, 1, 0);
      start_run(3);
      chk("full_busy", 64'(busy), 64'd1);
      wait_done("full", 50);
      chk("full_literal", last_word, 64'h0000_0300_0020_0001);

      // Partial word 10..14.
      load(5, 10, 0);
      start_run(5);
      wait_done("partial", 60);
      chk("partial_literal", last_word, 64'h0000_0000_00E0_000D);

      // Backpressure: a pending word held for 10 cycles, FIFO level frozen.
      ready_mode = 0;
      load(6, 'h100, 0);
      start_run(3);
      k = 0;
      while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
      chk("bp_valid_seen", 64'(out_valid), 64'd1);
      repeat (10) begin
         @(negedge clk);
         chk("bp_level", 64'(fq.size()), 64'd3);
      end
      ready_mode = 1;
      wait_done("bp", 30);
      fq.delete();
      @(posedge clk); #1;

      // Empty flag toggling every other cycle, 20 samples -> 7 words.
      gap_en = 1;
      load(20, 100, 0);
      start_run(20);
      wait_done("gaps", 400);
      chk("gaps_words7", 64'(words), 64'd7);
      gap_en = 0;

      // Zero count: done two cycles after start, nothing popped or emitted.
      load(2, 50, 0);
      start_run(0);
      @(negedge clk);
      chk("zero_done_early", 64'(done), 64'd0);
      @(negedge clk);
      chk("zero_done_t2", 64'(done), 64'd1);
      wait_done("zero", 10);
      fq.delete();
      @(posedge clk); #1;

      // Randomized runs with random backpressure and data.
      ready_mode = 2;
      for (int r = 0; r < 8; r++) begin
         int n = $urandom_range(1, 12);
         gap_en = r[0];
         load(n, 0, 1);
         start_run(n);
         wait_done("rand", 300);
      end
      gap_en = 0;
      ready_mode = 1;

      // Reset mid-FILL after two pops.
      load(6, 'h200, 0);
      start_run(6);
      k = 0;
      while (pops < 2 && k < 20) begin @(posedge clk); #2; k++; end
      chk("rst_mid_pops_reached", 64'(pops), 64'd2);
      afu_rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mid_pops", 64'(pops), 64'd2);
      chk("rst_mid_outs", {out_data[59:0], out_count, 1'b0, out_valid},
          64'd0);
      chk("rst_mid_ctl", 64'({out_last, busy, done, fifo_rd_en}), 64'd0);
      exp_data.delete(); exp_cnt.delete(); exp_last.delete();
      @(posedge clk); #1;
      afu_rst_n = 1'b1;
      fq.delete();
      @(posedge clk); #1;

      // Re-arm after reset; a second start while busy is ignored.
      load(8, 'h300, 0);
      start_run(3);
      num_samples = NSW'(5);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("rearm", 50);
      repeat (20) @(posedge clk);
      #1;
      chk("rearm_no_second_run", 64'(done_cnt), 64'd1);
      chk("rearm_fifo_left", 64'(fq.size()), 64'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
